// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencer for the 9-bit CPU.
//
// Drives the registered fetch address and applies the decode stage's
// control-flow requests. Priority in RUN, highest first: done, rts, jsr,
// br, stall, increment. Lower-priority requests in the same cycle are
// dropped. Subroutine calls go through a 16-entry target table and push
// their return address onto a small LIFO.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             pulse: enter RUN at pc 0 from IDLE/HALT/FAULT
//   stall             hold pc this cycle
//   br_en, br_off     relative branch, signed two's-complement offset
//   jsr_en, jsr_idx   call through target table entry jsr_idx
//   rts_en            return to the address on top of the stack
//   done              program done request, enters HALT
//   cfg_we/idx/addr   target table write port, active in every state
//   pc                current fetch address
//   running/halted/fault  state flags, registered
//   sp                stack occupancy, 0..STACK_D
module pc_fetch_unit #(
    parameter int unsigned PC_W    = 10,
    parameter int unsigned STACK_D = 4,
    parameter int unsigned TBL_N   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            br_en,
    input  logic [PC_W-1:0] br_off,
    input  logic            jsr_en,
    input  logic [3:0]      jsr_idx,
    input  logic            rts_en,
    input  logic            done,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_idx,
    input  logic [PC_W-1:0] cfg_addr,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            halted,
    output logic            fault,
    output logic [2:0]      sp
);

    localparam int unsigned IDX_W   = (STACK_D > 1) ? $clog2(STACK_D) : 1;
    localparam logic [2:0]  SP_FULL = 3'(STACK_D);

    typedef enum logic [1:0] {StIdle, StRun, StHalt, StFault} state_t;

    state_t          state;
    logic [PC_W-1:0] stack [STACK_D];
    logic [PC_W-1:0] tbl   [TBL_N];

    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;
    logic [PC_W-1:0]  pc_inc;

    assign top_idx  = IDX_W'(sp - 3'd1);
    assign push_idx = IDX_W'(sp);
    assign pc_inc   = pc + PC_W'(1);

    // Target table. Non-blocking write gives read-before-write to a jsr
    // indexing the same entry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TBL_N); i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl[cfg_idx] <= cfg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            pc      <= '0;
            sp      <= '0;
            running <= 1'b0;
            halted  <= 1'b0;
            fault   <= 1'b0;
            for (int i = 0; i < int'(STACK_D); i++) begin
                stack[i] <= '0;
            end
        end else begin
            unique case (state)
                StRun: begin
                    if (done) begin
                        state   <= StHalt;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (rts_en) begin
                        if (sp == 3'd0) begin
                            state   <= StFault;
                            running <= 1'b0;
                            fault   <= 1'b1;
                        end else begin
                            pc <= stack[top_idx];
                            sp <= sp - 3'd1;
                        end
                    end else if (jsr_en) begin
                        if (sp == SP_FULL) begin
                            state   <= StFault;
                            running <= 1'b0;
                            fault   <= 1'b1;
                        end else begin
                            stack[push_idx] <= pc_inc;
                            pc              <= tbl[jsr_idx];
                            sp              <= sp + 3'd1;
                        end
                    end else if (br_en) begin
                        pc <= pc + br_off;
                    end else if (!stall) begin
                        pc <= pc_inc;
                    end
                end
                default: begin
                    // Stack contents survive start; only the pointer resets.
                    if (start) begin
                        state   <= StRun;
                        pc      <= '0;
                        sp      <= '0;
                        running <= 1'b1;
                        halted  <= 1'b0;
                        fault   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    typedef struct {
        logic       start;
        logic       stall;
        logic       br_en;
        logic [9:0] br_off;
        logic       jsr_en;
        logic [3:0] jsr_idx;
        logic       rts_en;
        logic       done;
        logic       cfg_we;
        logic [3:0] cfg_idx;
        logic [9:0] cfg_addr;
    } in_t;

    typedef struct {
        in_t        in;
        int         exp_pc;
        int         exp_sp;
        logic [2:0] exp_fl;  // {fault, halted, running}
    } vec_t;

    localparam logic [2:0] FL_IDLE = 3'b000;
    localparam logic [2:0] FL_RUN  = 3'b001;
    localparam logic [2:0] FL_HALT = 3'b010;
    localparam logic [2:0] FL_FLT  = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stall = 1'b0, br_en = 1'b0, jsr_en = 1'b0;
    logic       rts_en = 1'b0, done = 1'b0, cfg_we = 1'b0;
    logic [9:0] br_off = '0, cfg_addr = '0;
    logic [3:0] jsr_idx = '0, cfg_idx = '0;
    logic [9:0] pc;
    logic       running, halted, fault;
    logic [2:0] sp;

    int errors = 0;
    int checks = 0;

    // Reference model: abstract state, queue stack, plain int arithmetic.
    int m_state;  // 0 idle, 1 run, 2 halt, 3 fault
    int m_pc;
    int m_stack[$];
    int m_tbl[16];

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stall    (stall),
        .br_en    (br_en),
        .br_off   (br_off),
        .jsr_en   (jsr_en),
        .jsr_idx  (jsr_idx),
        .rts_en   (rts_en),
        .done     (done),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_addr (cfg_addr),
        .pc       (pc),
        .running  (running),
        .halted   (halted),
        .fault    (fault),
        .sp       (sp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(bit st, bit stl, bit br, int off, bit jsr, int jidx,
                               bit rts, bit dn, bit we, int widx, int waddr);
        in_t i;
        i.start = st;   i.stall = stl;     i.br_en = br;   i.br_off = 10'(off);
        i.jsr_en = jsr; i.jsr_idx = 4'(jidx); i.rts_en = rts; i.done = dn;
        i.cfg_we = we;  i.cfg_idx = 4'(widx); i.cfg_addr = 10'(waddr);
        return i;
    endfunction

    function automatic in_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_pc = 0;
        m_stack.delete();
        for (int k = 0; k < 16; k++) m_tbl[k] = 0;
    endfunction

    function automatic void model_clock(in_t i);
        int old_t;
        old_t = m_tbl[i.jsr_idx];
        if (m_state != 1) begin
            if (i.start) begin
                m_state = 1;
                m_pc = 0;
                m_stack.delete();
            end
        end else if (i.done) begin
            m_state = 2;
        end else if (i.rts_en) begin
            if (m_stack.size() == 0) m_state = 3;
            else m_pc = m_stack.pop_back();
        end else if (i.jsr_en) begin
            if (m_stack.size() == 4) m_state = 3;
            else begin
                m_stack.push_back((m_pc + 1) % 1024);
                m_pc = old_t;
            end
        end else if (i.br_en) begin
            m_pc = (m_pc + int'(i.br_off)) % 1024;
        end else if (!i.stall) begin
            m_pc = (m_pc + 1) % 1024;
        end
        if (i.cfg_we) m_tbl[i.cfg_idx] = int'(i.cfg_addr);
    endfunction

    function automatic logic [2:0] m_flags();
        case (m_state)
            1: return FL_RUN;
            2: return FL_HALT;
            3: return FL_FLT;
            default: return FL_IDLE;
        endcase
    endfunction

    task automatic drive(input in_t i);
        start = i.start;   stall = i.stall;     br_en = i.br_en;   br_off = i.br_off;
        jsr_en = i.jsr_en; jsr_idx = i.jsr_idx; rts_en = i.rts_en; done = i.done;
        cfg_we = i.cfg_we; cfg_idx = i.cfg_idx; cfg_addr = i.cfg_addr;
    endtask

    task automatic compare_model();
        chk("model_pc", pc, m_pc);
        chk("model_sp", sp, m_stack.size());
        chk("model_flags", {fault, halted, running}, m_flags());
    endtask

    // Inputs are driven 1 time unit after an edge, outputs sampled 1 unit
    // after the next edge.
    task automatic cycle(input in_t i);
        drive(i);
        @(posedge clk);
        model_clock(i);
        #1;
        compare_model();
    endtask

    vec_t vt[$];

    task automatic add(input in_t i, input int p, input int s, input logic [2:0] f);
        vec_t v;
        v.in = i; v.exp_pc = p; v.exp_sp = s; v.exp_fl = f;
        vt.push_back(v);
    endtask

    initial begin
        model_reset();

        // Directed vectors from reset, expected values derived by hand.
        add(mk(0,0,0,0, 0,0, 0,0, 1,1,60),   0, 0, FL_IDLE);
        add(mk(0,0,0,0, 0,0, 0,0, 1,2,70),   0, 0, FL_IDLE);
        add(mk(1,0,0,0, 0,0, 0,0, 0,0,0),    0, 0, FL_RUN);
        for (int k = 1; k <= 5; k++) add(nop(), k, 0, FL_RUN);
        add(mk(0,0,0,0, 1,1, 0,0, 0,0,0),   60, 1, FL_RUN);
        add(nop(),                          61, 1, FL_RUN);
        add(mk(0,0,1,-2, 0,0, 0,0, 0,0,0),  59, 1, FL_RUN);
        add(mk(0,1,0,0, 0,0, 0,0, 0,0,0),   59, 1, FL_RUN);
        add(mk(0,0,0,0, 0,0, 1,0, 0,0,0),    6, 0, FL_RUN);
        add(mk(0,0,1,5, 1,2, 0,0, 0,0,0),   70, 1, FL_RUN);
        add(mk(0,0,0,0, 1,1, 0,0, 0,0,0),   60, 2, FL_RUN);
        add(mk(0,0,0,0, 0,0, 1,0, 0,0,0),   71, 1, FL_RUN);
        add(mk(0,0,0,0, 0,0, 1,0, 0,0,0),    7, 0, FL_RUN);
        add(mk(0,0,0,0, 0,0, 1,0, 0,0,0),    7, 0, FL_FLT);
        add(mk(0,1,1,5, 0,0, 0,0, 0,0,0),    7, 0, FL_FLT);
        add(mk(1,0,0,0, 0,0, 0,0, 1,1,100),  0, 0, FL_RUN);
        add(mk(0,0,0,0, 1,1, 0,0, 0,0,0),  100, 1, FL_RUN);
        add(mk(0,0,1,3, 1,2, 0,1, 0,0,0),  100, 1, FL_HALT);
        add(mk(1,0,0,0, 0,0, 0,0, 0,0,0),    0, 0, FL_RUN);
        add(mk(1,0,0,0, 0,0, 0,0, 0,0,0),    1, 0, FL_RUN);
        add(mk(0,0,0,0, 1,1, 0,0, 1,1,200), 100, 1, FL_RUN);
        add(mk(0,0,0,0, 0,0, 1,0, 0,0,0),    2, 0, FL_RUN);
        add(mk(0,0,0,0, 1,1, 0,0, 0,0,0),  200, 1, FL_RUN);
        add(mk(0,0,0,0, 0,0, 1,0, 0,0,0),    3, 0, FL_RUN);

        // Reset state.
        drive(nop());
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc, 0);
        chk("reset_sp", sp, 0);
        chk("reset_flags", {fault, halted, running}, FL_IDLE);
        rst_n = 1'b1;

        foreach (vt[k]) begin
            cycle(vt[k].in);
            chk($sformatf("vec%0d_pc", k), pc, vt[k].exp_pc);
            chk($sformatf("vec%0d_sp", k), sp, vt[k].exp_sp);
            chk($sformatf("vec%0d_flags", k), {fault, halted, running}, vt[k].exp_fl);
        end

        // Stack overflow: four calls fill it, the fifth faults with pc frozen.
        for (int k = 0; k < 4; k++) cycle(mk(0,0,0,0, 1,2, 0,0, 0,0,0));
        chk("ovf_sp4", sp, 4);
        chk("ovf_pc", pc, 70);
        cycle(mk(0,0,0,0, 1,2, 0,0, 0,0,0));
        chk("ovf_fault", fault, 1);
        chk("ovf_running", running, 0);
        chk("ovf_pc_frozen", pc, 70);
        cycle(mk(1,0,0,0, 0,0, 0,0, 0,0,0));
        chk("restart_pc", pc, 0);
        chk("restart_sp", sp, 0);
        chk("restart_running", running, 1);

        // Wrap 1023 -> 0, then branches both directions.
        cycle(mk(0,0,0,0, 0,0, 0,0, 1,3,1022));
        cycle(mk(0,0,0,0, 1,3, 0,0, 0,0,0));
        chk("wrap_pre", pc, 1022);
        cycle(nop());
        chk("wrap_1023", pc, 1023);
        cycle(nop());
        chk("wrap_0", pc, 0);
        cycle(mk(0,0,0,0, 0,0, 0,0, 1,4,31));
        cycle(mk(0,0,0,0, 1,4, 0,0, 0,0,0));
        chk("br_at31", pc, 31);
        cycle(mk(0,0,1,-2, 0,0, 0,0, 0,0,0));
        chk("br_minus2", pc, 29);
        cycle(mk(0,0,1,11, 0,0, 0,0, 0,0,0));
        cycle(mk(0,0,1,3, 0,0, 0,0, 0,0,0));
        chk("br_plus3", pc, 43);
        cycle(mk(0,0,1,-6, 0,0, 0,0, 0,0,0));
        cycle(mk(0,1,0,0, 0,0, 0,0, 0,0,0));
        chk("stall_37", pc, 37);

        // Asynchronous reset in the middle of a stalled cycle.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_pc", pc, 0);
        chk("arst_sp", sp, 0);
        chk("arst_flags", {fault, halted, running}, FL_IDLE);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(mk(1,0,0,0, 0,0, 0,0, 0,0,0));
        cycle(mk(0,0,0,0, 1,1, 0,0, 0,0,0));
        chk("arst_tbl_cleared", pc, 0);
        chk("arst_jsr_sp", sp, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            in_t r;
            r.start    = ($urandom_range(15) == 0);
            r.done     = ($urandom_range(31) == 0);
            r.rts_en   = ($urandom_range(7) == 0);
            r.jsr_en   = ($urandom_range(7) == 0);
            r.br_en    = ($urandom_range(5) == 0);
            r.stall    = ($urandom_range(5) == 0);
            r.br_off   = 10'($urandom);
            r.jsr_idx  = 4'($urandom);
            r.cfg_we   = ($urandom_range(3) == 0);
            r.cfg_idx  = 4'($urandom);
            r.cfg_addr = 10'($urandom);
            cycle(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
